// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Opcodes, instruction field positions and phase encodings
//               shared by the fetch stage and its next-PC selector.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [3:0] OPC_AND  = 4'h0;
    localparam logic [3:0] OPC_OR   = 4'h1;
    localparam logic [3:0] OPC_XOR  = 4'h2;
    localparam logic [3:0] OPC_ADD  = 4'h3;
    localparam logic [3:0] OPC_SUB  = 4'h4;
    localparam logic [3:0] OPC_SLT  = 4'h5;
    localparam logic [3:0] OPC_ADDI = 4'h6;
    localparam logic [3:0] OPC_J    = 4'h7;
    localparam logic [3:0] OPC_BEQ  = 4'h8;
    localparam logic [3:0] OPC_BNE  = 4'h9;
    localparam logic [3:0] OPC_LW   = 4'hE;
    localparam logic [3:0] OPC_SW   = 4'hF;

    localparam int OPC_HI = 31;
    localparam int RA_HI  = 27;
    localparam int RB_HI  = 23;
    localparam int RC_HI  = 19;
    localparam int IMM_HI = 15;

    typedef enum logic [1:0] {
        PH_FETCH = 2'b00,
        PH_EXEC  = 2'b01
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pc_next_sel
// Description : Combinational next-PC selection: sequential, relative branch
//               or absolute jump (jump has priority), all modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_pc_next_sel #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [15:0]       i_imm,
    input  logic              i_take_jump,
    input  logic              i_take_branch,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic [ADDR_W-1:0] o_pc_plus1,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_imm_sx;
    logic [ADDR_W-1:0] w_branch_pc;

    assign w_imm_sx    = ADDR_W'($signed(i_imm));
    assign o_pc_plus1  = i_pc + ADDR_W'(1);
    assign w_branch_pc = o_pc_plus1 + w_imm_sx;

    always_comb begin
        o_next_pc = o_pc_plus1;
        if (i_take_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_take_branch) begin
            o_next_pc = w_branch_pc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage with PC/IR and a handshake-aware
//               FETCH/EXEC sequencer tolerating memory waits and exec holds.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               hold,
    input  logic               take_jump,
    input  logic               take_branch,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         ra,
    output logic [3:0]         rb,
    output logic [3:0]         rc,
    output logic [15:0]        imm,
    output logic               exec_valid,
    output logic [1:0]         phase
);

    phase_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_req;
    logic                r_exec_valid;
    logic [ADDR_W-1:0]   w_next_pc;

    fetch_unit_pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .i_pc          (r_pc),
        .i_imm         (r_ir[IMM_HI -: 16]),
        .i_take_jump   (take_jump),
        .i_take_branch (take_branch),
        .i_jump_target (jump_target),
        .o_pc_plus1    (pc_plus1),
        .o_next_pc     (w_next_pc)
    );

    // r_req/r_exec_valid are registered copies of the phase decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PH_FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_req        <= 1'b1;
            r_exec_valid <= 1'b0;
        end else begin
            case (r_state)
                PH_FETCH: begin
                    if (imem_ack) begin
                        r_ir         <= imem_rdata;
                        r_state      <= PH_EXEC;
                        r_req        <= 1'b0;
                        r_exec_valid <= 1'b1;
                    end
                end
                PH_EXEC: begin
                    if (!hold) begin
                        r_pc         <= w_next_pc;
                        r_state      <= PH_FETCH;
                        r_req        <= 1'b1;
                        r_exec_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= PH_FETCH;
                    r_req        <= 1'b1;
                    r_exec_valid <= 1'b0;
                end
            endcase
        end
    end

    // Gating with reset drops the request the instant reset asserts.
    assign imem_req   = r_req & reset;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign instr      = r_ir;
    assign opcode     = r_ir[OPC_HI -: 4];
    assign ra         = r_ir[RA_HI -: 4];
    assign rb         = r_ir[RB_HI -: 4];
    assign rc         = r_ir[RC_HI -: 4];
    assign imm        = r_ir[IMM_HI -: 16];
    assign exec_valid = r_exec_valid;
    assign phase      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        hold;
    logic        take_jump;
    logic        take_branch;
    logic [15:0] jump_target;

    logic        imem_req,  d2_req;
    logic [15:0] imem_addr, d2_addr;
    logic [15:0] pc,        d2_pc;
    logic [15:0] pc_plus1,  d2_pc1;
    logic [31:0] instr,     d2_instr;
    logic [3:0]  opcode, ra, rb, rc, d2_opc, d2_ra, d2_rb, d2_rc;
    logic [15:0] imm,       d2_imm;
    logic        exec_valid, d2_ev;
    logic [1:0]  phase,     d2_phase;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_pc;
    logic [31:0] m_ir;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .hold(hold),
        .take_jump(take_jump), .take_branch(take_branch), .jump_target(jump_target),
        .pc(pc), .pc_plus1(pc_plus1), .instr(instr), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .imm(imm), .exec_valid(exec_valid), .phase(phase)
    );

    fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .hold(hold),
        .take_jump(take_jump), .take_branch(take_branch), .jump_target(jump_target),
        .pc(d2_pc), .pc_plus1(d2_pc1), .instr(d2_instr), .opcode(d2_opc),
        .ra(d2_ra), .rb(d2_rb), .rc(d2_rc), .imm(d2_imm), .exec_valid(d2_ev), .phase(d2_phase)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One instruction: fetch with wait states, execute with hold cycles,
    // then resolve the control decision into the model PC.
    task automatic do_instr(input int waits, input logic [31:0] data, input int holds,
                            input logic tj, input logic tbr, input logic [15:0] jt);
        logic [15:0] p1;
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_ev", exec_valid, 1'b0);
        chk("fetch_phase", phase, 2'b00);
        for (int w = 0; w < waits; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_ev", exec_valid, 1'b0);
            chk("wait_ir", instr, m_ir);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        m_ir = data;
        for (int h = 0; h < holds; h++) begin
            chk("hold_ev", exec_valid, 1'b1);
            chk("hold_req", imem_req, 1'b0);
            chk("hold_ir", instr, m_ir);
            chk("hold_opc", opcode, m_ir[31:28]);
            chk("hold_pc", pc, m_pc);
            hold        = 1'b1;
            take_jump   = 1'($urandom);
            take_branch = 1'($urandom);
            jump_target = 16'($urandom);
            imem_ack    = 1'($urandom);
            imem_rdata  = $urandom;
            step();
        end
        chk("exec_ev", exec_valid, 1'b1);
        chk("exec_req", imem_req, 1'b0);
        chk("exec_phase", phase, 2'b01);
        chk("exec_ir", instr, m_ir);
        chk("exec_fields", {opcode, ra, rb, rc, imm}, m_ir);
        chk("exec_pc", pc, m_pc);
        p1 = m_pc + 16'd1;
        chk("exec_pc1", pc_plus1, p1);
        hold        = 1'b0;
        imem_ack    = 1'b0;
        take_jump   = tj;
        take_branch = tbr;
        jump_target = jt;
        step();
        take_jump   = 1'b0;
        take_branch = 1'b0;
        if (tj)
            m_pc = jt;
        else if (tbr)
            m_pc = 16'(int'(p1) + int'($signed(data[15:0])));
        else
            m_pc = p1;
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; hold = 1'b0;
        take_jump = 1'b0; take_branch = 1'b0; jump_target = '0;
        m_pc = 16'h0000; m_ir = '0;
        step(); step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_ev", exec_valid, 1'b0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", instr, 32'h0);
        chk("rst_phase", phase, 2'b00);
        chk("rst_wrap_pc", d2_pc, 16'hFFFF);
        #3 reset = 1'b1;
        #1;

        // Zero-wait sequential fetch and wrap on the RESET_PC=0xFFFF copy
        do_instr(0, 32'h4123_0000, 0, 1'b0, 1'b0, 16'h0);
        chk("zw_addr1", imem_addr, 16'h0001);
        chk("wrap_addr", d2_addr, 16'h0000);
        do_instr(0, 32'h1456_0000, 0, 1'b0, 1'b0, 16'h0);
        chk("zw_addr2", imem_addr, 16'h0002);
        chk("zw_opc", instr[31:28], 4'h1);

        // Wait states, then jump to 0x0010 and a backward branch
        do_instr(3, 32'h7000_0000, 0, 1'b1, 1'b0, 16'h0010);
        do_instr(0, 32'h8000_FFFC, 0, 1'b0, 1'b1, 16'h0);
        chk("branch_addr", imem_addr, 16'h000D);
        do_instr(1, 32'h8000_0040, 0, 1'b1, 1'b1, 16'h0200);
        chk("jump_prio_addr", imem_addr, 16'h0200);

        // Hold with ignored take_* pulses
        do_instr(0, 32'h3ABC_1234, 2, 1'b0, 1'b0, 16'h0);
        chk("hold_next_addr", imem_addr, 16'h0201);

        // Branch wrap across the top of the address space
        do_instr(0, 32'h7000_0000, 0, 1'b1, 1'b0, 16'hFFFE);
        do_instr(2, 32'h9000_0003, 0, 1'b0, 1'b1, 16'h0);
        chk("branch_wrap_addr", imem_addr, 16'h0002);

        // Reset mid-fetch at pc=0x0005 with a stale ack during reset
        do_instr(0, 32'h7000_0000, 0, 1'b1, 1'b0, 16'h0005);
        imem_ack = 1'b0;
        step();
        chk("pend_addr", imem_addr, 16'h0005);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_pc", pc, 16'h0000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("stale_ack_ir", instr, 32'h0);
        chk("stale_ack_phase", phase, 2'b00);
        imem_ack = 1'b0;
        #3 reset = 1'b1;
        #1;
        m_pc = 16'h0000;
        m_ir = '0;
        do_instr(0, 32'h4123_0000, 0, 1'b0, 1'b0, 16'h0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            int          w;
            int          h;
            logic        tj;
            logic        tbr;
            w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            h   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            tj  = ($urandom_range(0, 4) == 0);
            tbr = ($urandom_range(0, 2) == 0);
            do_instr(w, $urandom, h, tj, tbr, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: holds PC and instruction register (IR), runs a FETCH/EXEC phase FSM, and drives the instruction-memory request interface.
- Supplies opcode and instruction fields to the control unit; consumes that unit's jump/branch decisions to form the next PC.
- Sits directly upstream of control; replaces the free-running two-phase toggle with a handshake-aware sequencer that tolerates memory wait states and execute stalls.

Parameters:
- ADDR_W, 16, PC / instruction-address width (word addressed).
- INSTR_W, 32, instruction width; must be 32 (field map below is fixed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  instruction read request.
- imem_addr  out  ADDR_W  read address, equals pc while imem_req=1.
- imem_rdata  in  INSTR_W  read data, valid when imem_ack=1.
- imem_ack  in  1  read complete; may arrive in the same cycle as imem_req or later.
- hold  in  1  extends EXEC phase (e.g. data memory busy).
- take_jump  in  1  control decision: absolute jump.
- take_branch  in  1  control decision: relative branch taken.
- jump_target  in  ADDR_W  absolute jump address (register operand).
- pc  out  ADDR_W  address of the instruction in IR.
- pc_plus1  out  ADDR_W  pc+1 mod 2^ADDR_W.
- instr  out  INSTR_W  IR contents.
- opcode  out  4  instr[31:28].
- ra, rb, rc  out  4 each  instr[27:24], [23:20], [19:16].
- imm  out  16  instr[15:0].
- exec_valid  out  1  high in every EXEC-phase cycle.
- phase  out  2  FSM state encoding.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, IR=0, state=FETCH, imem_req=0, exec_valid=0. imem_req is gated by reset so it is 0 during reset.
- FSM states: FETCH=2'b00, EXEC=2'b01. Encodings 2'b10 and 2'b11 are illegal and recover to FETCH on the next edge.
- FETCH phase:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On an edge with imem_ack=1: IR<=imem_rdata, state<=EXEC.
  - Without ack: remain in FETCH; IR and pc unchanged.
- EXEC phase:
  - exec_valid=1 and imem_req=0.
  - If hold=1: stay in EXEC; pc and IR are frozen and take_* inputs are ignored.
  - If hold=0: pc<=next_pc, state<=FETCH.
- next_pc priority:
  - take_jump=1 → jump_target (wins if take_branch is also 1).
  - else take_branch=1 → pc_plus1 + sign_extend(imm), truncated to ADDR_W.
  - else pc_plus1.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_W. pc=all-ones with no branch goes to 0.
- Zero-wait memory (ack in the same cycle as req): strict 2-cycle rhythm FETCH,EXEC,FETCH,... with exec_valid toggling each cycle.
- imem_ack while not in FETCH is ignored; no state or IR change.
- Reset asserted mid-FETCH or mid-EXEC abandons the operation immediately. After release, the first rising edge is in FETCH with req=1 at RESET_PC.
- Field outputs are combinational slices of IR. They are stable throughout EXEC, including hold cycles.

Decomposition:
- Shared package holds:
  - opcode constants (AND=0x0 … SW=0xF, J=0x7, BEQ=0x8, BNE=0x9);
  - field bit positions (OPC_HI=31, RA_HI=27, RB_HI=23, RC_HI=19, IMM_HI=15);
  - phase encodings FETCH/EXEC.
- One sub-module, pc_next_sel: combinational pc_plus1, branch adder, jump/branch priority mux.

Test Plan:
- Zero-wait sequential: reset release, memory acks the same cycle with mem[0]=0x4123_0000, mem[1]=0x1456_0000 → imem_addr 0,1,2 on cycles 0,2,4; opcode 0x4 then 0x1; ra=1, rb=2, rc=3 for the first instruction.
- Wait states: ack delayed 3 cycles → imem_req high 4 cycles, imem_addr stable, exec_valid=0 throughout, IR updated only on the ack edge.
- Branch/jump priority:
  - pc=0x0010, imm=0xFFFC, take_branch=1 → next fetch at 0x000D.
  - With take_jump=1 and jump_target=0x0200 as well → next fetch at 0x0200.
- Hold: hold=1 for 2 EXEC cycles → exec_valid high 3 cycles; pc/opcode unchanged; take_jump pulsed only during hold has no effect.
- Wrap: RESET_PC=0xFFFF, no branch → second fetch address 0x0000. Branch at pc=0xFFFE with imm=0x0003 → next fetch at 0x0002.
- Reset mid-fetch: reset=0 during a pending FETCH at pc=0x0005 → imem_req drops asynchronously; after release fetch restarts at RESET_PC; a stale ack arriving during reset is ignored.
